// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked multi-cycle ALU with iterative multiply/divide and status flags
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags
);
  localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_MUL = 6'b000010,
                         OP_DIV = 6'b000011, OP_CMP = 6'b000100, OP_NOT = 6'b001000,
                         OP_AND = 6'b001001, OP_OR  = 6'b001010, OP_XOR = 6'b001011,
                         OP_NOP = 6'b010000;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;

  logic             live;
  logic             is_mul;
  logic [WIDTH-1:0] opd, p_hi, p_lo;
  logic [CW-1:0]    count;
  logic             accept, long_op;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] s_res, s_hi;
  logic             s_c, s_v, s_err, s_z_ok;
  logic [3:0]       s_flags;

  logic [WIDTH:0]   mul_sum, div_sh;
  logic [WIDTH-1:0] div_sub, it_hi, it_lo;
  logic             div_ge;

  assign accept  = in_valid & in_ready;
  assign long_op = (op == OP_MUL) || (op == OP_DIV && b != '0);

  // Single-cycle ops are evaluated straight from the request and registered on accept
  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    s_res  = '0;
    s_hi   = '0;
    s_c    = 1'b0;
    s_v    = 1'b0;
    s_err  = 1'b0;
    s_z_ok = 1'b1;
    case (op)
      OP_ADD: begin
        s_res = sum[WIDTH-1:0];
        s_c   = sum[WIDTH];
        s_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        s_res = diff[WIDTH-1:0];
        s_c   = diff[WIDTH];
        s_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_DIV: begin
        s_res  = '1;
        s_hi   = a;
        s_err  = 1'b1;
        s_z_ok = 1'b0;
      end
      OP_MUL, OP_NOP: begin
      end
      OP_CMP: s_res = (a == b) ? '0 : ((a > b) ? WIDTH'(1) : WIDTH'(2));
      OP_NOT: s_res = ~a;
      OP_AND: s_res = a & b;
      OP_OR:  s_res = a | b;
      OP_XOR: s_res = a ^ b;
      default: s_err = 1'b1;
    endcase
    s_flags = {s_z_ok && (s_res == '0), s_c, s_v, s_err};
  end

  // One iteration: multiply shifts {p_hi,p_lo} right; divide shifts the quotient into p_lo
  always_comb begin
    mul_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, opd} : '0);
    div_sh  = {p_hi, p_lo[WIDTH-1]};
    div_ge  = div_sh >= {1'b0, opd};
    div_sub = div_sh[WIDTH-1:0] - opd;
    if (is_mul) begin
      it_hi = mul_sum[WIDTH:1];
      it_lo = {mul_sum[0], p_lo[WIDTH-1:1]};
    end else begin
      it_hi = div_ge ? div_sub : div_sh[WIDTH-1:0];
      it_lo = {p_lo[WIDTH-2:0], div_ge};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = long_op ? BUSY : DONE;
      BUSY:    if (count == LAST) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = live && (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      live      <= 1'b0;
      is_mul    <= 1'b0;
      opd       <= '0;
      p_hi      <= '0;
      p_lo      <= '0;
      count     <= '0;
      result    <= '0;
      result_hi <= '0;
      flags     <= '0;
    end else begin
      live <= 1'b1;
      if (accept) begin
        if (long_op) begin
          is_mul <= (op == OP_MUL);
          opd    <= (op == OP_MUL) ? a : b;
          p_hi   <= '0;
          p_lo   <= (op == OP_MUL) ? b : a;
          count  <= '0;
        end else begin
          result    <= s_res;
          result_hi <= s_hi;
          flags     <= s_flags;
        end
      end else if (state == BUSY) begin
        p_hi  <= it_hi;
        p_lo  <= it_lo;
        count <= count + CW'(1);
        if (count == LAST) begin
          result    <= it_lo;
          result_hi <= it_hi;
          flags     <= {is_mul ? ({it_hi, it_lo} == '0) : (it_lo == '0), 3'b000};
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed vector bench for alu_seq at WIDTH=8 and WIDTH=16
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  op;
  logic [15:0] a, b;
  logic        iv8, ir8, ov8, or8;
  logic        iv16, ir16, ov16, or16;
  logic [7:0]  res8, hi8;
  logic [15:0] res16, hi16;
  logic [3:0]  fl8, fl16;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .op(op),
    .a(a[7:0]), .b(b[7:0]), .out_valid(ov8), .out_ready(or8),
    .result(res8), .result_hi(hi8), .flags(fl8)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .op(op),
    .a(a), .b(b), .out_valid(ov16), .out_ready(or16),
    .result(res16), .result_hi(hi16), .flags(fl16)
  );

  typedef struct {
    int          w;
    logic [5:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [15:0] hi;
    logic [3:0]  fl;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int w, input logic [5:0] o, input logic [15:0] va,
                              input logic [15:0] vb, input logic [15:0] r, input logic [15:0] h,
                              input logic [3:0] f, input int l, input string n);
    vec_t v;
    v.w = w; v.op = o; v.a = va; v.b = vb; v.res = r; v.hi = h; v.fl = f; v.lat = l; v.name = n;
    vecs.push_back(v);
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic get_ir(input int w); return (w == 8) ? ir8 : ir16; endfunction
  function automatic logic get_ov(input int w); return (w == 8) ? ov8 : ov16; endfunction
  function automatic logic [15:0] get_res(input int w); return (w == 8) ? {8'h00, res8} : res16; endfunction
  function automatic logic [15:0] get_hi(input int w); return (w == 8) ? {8'h00, hi8} : hi16; endfunction
  function automatic logic [3:0] get_fl(input int w); return (w == 8) ? fl8 : fl16; endfunction

  task automatic set_iv(input int w, input logic v);
    if (w == 8) iv8 = v; else iv16 = v;
  endtask

  task automatic set_or(input int w, input logic v);
    if (w == 8) or8 = v; else or16 = v;
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, " ir8"}, 32'(ir8), 0);
    check({name, " ov8"}, 32'(ov8), 0);
    check({name, " res8"}, 32'(res8), 0);
    check({name, " hi8"}, 32'(hi8), 0);
    check({name, " fl8"}, 32'(fl8), 0);
    check({name, " ir16"}, 32'(ir16), 0);
    check({name, " ov16"}, 32'(ov16), 0);
  endtask

  // Entered and left at a negedge; operands are scrambled right after accept
  task automatic run_vec(input vec_t v);
    int lat;
    int guard;
    string n;
    n = $sformatf("%s/w%0d", v.name, v.w);
    guard = 0;
    while (!get_ir(v.w) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({n, " in_ready"}, 32'(get_ir(v.w)), 1);
    op = v.op; a = v.a; b = v.b;
    set_iv(v.w, 1'b1);
    @(posedge clk);
    #1;
    set_iv(v.w, 1'b0);
    op = 6'h3f; a = 16'hA5A5; b = 16'h5A5A;
    @(negedge clk);
    lat = 1;
    while (!get_ov(v.w) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({n, " latency"}, 32'(lat), 32'(v.lat));
    check({n, " result"}, 32'(get_res(v.w)), 32'(v.res));
    check({n, " result_hi"}, 32'(get_hi(v.w)), 32'(v.hi));
    check({n, " flags"}, 32'(get_fl(v.w)), 32'(v.fl));
    set_or(v.w, 1'b1);
    @(posedge clk);
    #1;
    set_or(v.w, 1'b0);
    @(negedge clk);
    check({n, " drained"}, 32'({get_ir(v.w), get_ov(v.w)}), 32'b10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    rst_n = 1'b0; iv8 = 0; iv16 = 0; or8 = 0; or16 = 0; op = '0; a = '0; b = '0;

    add(8,  6'b000000, 200, 100, 44, 0, 4'b0100, 1, "add_carry");
    add(8,  6'b000000, 100, 100, 200, 0, 4'b0010, 1, "add_ovf");
    add(8,  6'b000000, 128, 128, 0, 0, 4'b1110, 1, "add_zero");
    add(8,  6'b000001, 5, 7, 254, 0, 4'b0100, 1, "sub_borrow");
    add(8,  6'b000001, 127, 255, 128, 0, 4'b0110, 1, "sub_ovf");
    add(8,  6'b000010, 255, 255, 1, 254, 4'b0000, 9, "mul_max");
    add(8,  6'b000010, 0, 77, 0, 0, 4'b1000, 9, "mul_zero");
    add(8,  6'b000010, 13, 11, 143, 0, 4'b0000, 9, "mul_small");
    add(8,  6'b000011, 100, 7, 14, 2, 4'b0000, 9, "div");
    add(8,  6'b000011, 9, 0, 255, 9, 4'b0001, 1, "div_zero");
    add(8,  6'b000011, 3, 10, 0, 3, 4'b1000, 9, "div_q0");
    add(8,  6'b000011, 255, 1, 255, 0, 4'b0000, 9, "div_by1");
    add(8,  6'b000100, 5, 5, 0, 0, 4'b1000, 1, "cmp_eq");
    add(8,  6'b000100, 9, 3, 1, 0, 4'b0000, 1, "cmp_gt");
    add(8,  6'b001000, 16'h0F, 0, 16'hF0, 0, 4'b0000, 1, "not");
    add(8,  6'b001000, 16'hFF, 0, 0, 0, 4'b1000, 1, "not_zero");
    add(8,  6'b001001, 16'hCC, 16'hAA, 16'h88, 0, 4'b0000, 1, "and");
    add(8,  6'b001010, 16'hCC, 16'hAA, 16'hEE, 0, 4'b0000, 1, "or");
    add(8,  6'b001011, 16'hCC, 16'hAA, 16'h66, 0, 4'b0000, 1, "xor");
    add(8,  6'b001011, 16'h5A, 16'h5A, 0, 0, 4'b1000, 1, "xor_zero");
    add(8,  6'b010000, 3, 4, 0, 0, 4'b1000, 1, "nop");
    add(8,  6'b000111, 3, 4, 0, 0, 4'b1001, 1, "illegal");
    add(16, 6'b000000, 16'hFFFF, 1, 0, 0, 4'b1100, 1, "add_wrap");
    add(16, 6'b000001, 16'h7FFF, 16'hFFFF, 16'h8000, 0, 4'b0110, 1, "sub_ovf");
    add(16, 6'b000010, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 4'b0000, 17, "mul_max");
    add(16, 6'b000010, 300, 500, 16'h49F0, 16'h0002, 4'b0000, 17, "mul_mid");
    add(16, 6'b000011, 50000, 123, 406, 62, 4'b0000, 17, "div");
    add(16, 6'b000011, 1234, 0, 16'hFFFF, 1234, 4'b0001, 1, "div_zero");
    add(16, 6'b000100, 16'h1000, 16'h2000, 2, 0, 4'b0000, 1, "cmp_lt");
    add(16, 6'b001011, 16'hFFFF, 16'h00FF, 16'hFF00, 0, 4'b0000, 1, "xor");
    add(16, 6'b100000, 7, 7, 0, 0, 4'b1001, 1, "illegal");

    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    check("in_ready before first edge", 32'(ir8), 0);
    @(negedge clk);
    check("in_ready after reset", 32'({ir8, ir16}), 32'b11);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-pressure with in_valid held high and operands changing during DONE
    op = 6'b000100; a = 3; b = 9; iv8 = 1'b1;
    @(posedge clk);
    #1;
    op = 6'b001011; a = 5; b = 3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp hold %0d", i), 32'({ov8, ir8, res8, fl8}), 32'({1'b1, 1'b0, 8'd2, 4'b0000}));
    end
    or8 = 1'b1;
    @(posedge clk);
    #1;
    or8 = 1'b0;
    @(negedge clk);
    check("bp in_ready after drain", 32'({ir8, ov8}), 32'b10);
    @(posedge clk);
    #1;
    iv8 = 1'b0;
    @(negedge clk);
    check("bp held request result", 32'({ov8, res8}), 32'({1'b1, 8'd6}));
    or8 = 1'b1;
    @(posedge clk);
    #1;
    or8 = 1'b0;
    @(negedge clk);

    // Reset during the fourth cycle of a multiply discards it
    op = 6'b000010; a = 255; b = 255; iv8 = 1'b1;
    @(posedge clk);
    #1;
    iv8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero_outputs("mid-mul reset");
    check("mid-mul hi16", 32'(hi16), 0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ov8) seen++;
    end
    check("no out_valid after abort", 32'(seen), 0);
    check("in_ready after abort", 32'(ir8), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked, multi-cycle ALU. Successor of the 8-bit combinational ALU.
- Keeps the same 6-bit opcode map and adds:
  - WIDTH generalisation
  - iterative multiply (full 2W product) and restoring divide (quotient plus remainder)
  - status flags
  - valid/ready flow control
- Sits between the microprocessor's decode/operand-fetch stage and register writeback. Writeback stalls on out_valid.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operation request valid
in_ready  output  1  block can accept a request (high only in IDLE)
op  input  6  opcode, sampled on accept
a  input  WIDTH  operand A, sampled on accept
b  input  WIDTH  operand B, sampled on accept
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  primary result (sum, difference, product low, quotient, logic, compare code)
result_hi  output  WIDTH  product high half (MUL) or remainder (DIV), else 0
flags  output  4  {z, c, v, err}

Behaviour:
- Clock and reset:
  - One clock: clk.
  - Reset is synchronous and active-low on rst_n, sampled on the clk rising edge.
  - While rst_n=0: state=IDLE, in_ready=0, out_valid=0, result=0, result_hi=0, flags=0.
  - in_ready rises the first cycle after rst_n returns high.
- Accept: occurs on a cycle with in_valid & in_ready. op, a and b are registered. Inputs are ignored at all other times.
- States:
  - IDLE: in_ready=1.
  - On accept with MUL or DIV (divisor nonzero) -> BUSY; every other op -> DONE.
  - BUSY: one iteration per cycle, WIDTH iterations, then -> DONE.
  - DONE: out_valid=1. Outputs held stable until out_ready=1, then -> IDLE next cycle.
  - No accept in the cycle the result drains; back-to-back throughput is one op per 2 cycles for 1-cycle ops.
- Latency, accept edge to out_valid:
  - 1 cycle for all single-cycle ops.
  - WIDTH+1 cycles for MUL and for DIV with a nonzero divisor.
- Opcodes (unsigned unless noted):
  - 000000 ADD: result=a+b mod 2^W. c=carry-out; v=signed overflow.
  - 000001 SUB: result=a-b mod 2^W. c=borrow (a<b); v=signed overflow.
  - 000010 MUL: shift-add, one partial product per cycle. {result_hi,result}=a*b.
  - 000011 DIV: restoring, one quotient bit per cycle, MSB first. result=a/b, result_hi=a%b.
  - 000100 CMP: result[1:0]=00 if a==b, 01 if a>b, 10 if a<b; upper bits 0.
  - 001000 NOT: result=~a.
  - 001001 AND, 001010 OR, 001011 XOR: bitwise on a and b.
  - 010000 NOP: result=0; flags all 0 except z.
  - Any other opcode: result=0, result_hi=0, err=1, latency 1.
- Flags:
  - z=1 when result==0 (MUL: full 2W product ==0; DIV: quotient ==0).
  - c and v are 0 for every op except ADD and SUB.
  - err: illegal opcode or divide by zero only.
- Divide by zero (b==0): result=all ones, result_hi=a, err=1, z=0. Latency 1; BUSY is not entered.
- result_hi=0 for every op except MUL and DIV.
- Operand changes on a/b/op while BUSY or DONE have no effect.
- rst_n=0 during BUSY or DONE aborts the operation and discards the pending result. No out_valid is produced for it.
- in_valid may be held high across DONE. The request is accepted only once the block is back in IDLE.

Test Plan:
- Reset, then ADD a=200 b=100 -> one cycle after accept: out_valid=1, result=44, c=1, v=0, z=0.
- SUB a=5 b=7 -> result=254, c=1, v=0. Then SUB a=127 b=255 -> result=128, c=1, v=1.
- MUL a=255 b=255 -> out_valid exactly 9 cycles after accept; result_hi=254, result=1. MUL a=0 b=77 -> z=1.
- DIV a=100 b=7 -> 9 cycles, result=14, result_hi=2. DIV a=9 b=0 -> 1 cycle, result=255, result_hi=9, err=1.
- Back-pressure: CMP a=3 b=9 with out_ready low 5 cycles:
  - result=2 held stable and in_ready=0 throughout
  - drains on out_ready=1; in_ready=1 the next cycle
  - opcode 000111 -> err=1, result=0.
- rst_n low at cycle 4 of a MUL -> outputs zero next edge, no out_valid. Repeat the full suite at WIDTH=16: MUL 65535*65535 -> hi=65534, lo=1, latency 17.
